reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- 16-bit register file that directly consumes the 5-bit write-register address produced by the RegDst address mux. It sits between the decode/RegDst select and the ALU operand inputs of the single-cycle datapath.
- Writes pass through a one-entry write-back staging buffer before committing to the array.
- Reads are combinational, with a bypass from the staging buffer, so software sees normal single-cycle register semantics.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 16, register/data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (must equal 2**ADDR_W)
- BYPASS, 1, 1 = reads forward from the staging buffer; 0 = reads see the array only (debug)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- reg_write  in  1  write enable from control (RegWrite)
- write_addr  in  ADDR_W  destination register; driven by the RegDst mux output
- write_data  in  DATA_W  write-back data (ALU result or memory data)
- read_addr1  in  ADDR_W  rs read address
- read_addr2  in  ADDR_W  rt read address
- read_data1  out  DATA_W  rs operand
- read_data2  out  DATA_W  rt operand
- wb_pending  out  1  staging buffer holds an uncommitted write

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset: on any rising edge with reset=1:
  - all NUM_REGS array entries cleared to 0;
  - pend_valid=0, pend_addr=0, pend_data=0;
  - wb_pending=0.
  - With reset=1 the outputs therefore read 0 for all addresses from the following cycle on.
- Reset mid-operation: reset overrides everything. The pending write is discarded and not committed. Any write presented in the same cycle is ignored.
- Staging buffer, each rising edge with reset=0:
  - Commit: if pend_valid=1, array[pend_addr] <= pend_data.
  - Capture: if reg_write=1 and write_addr!=0, then pend_valid<=1, pend_addr<=write_addr, pend_data<=write_data. Otherwise pend_valid<=0.
  - Commit and capture occur on the same edge without conflict. If both target the same address, the array receives the old data and the buffer holds the new data, which wins on reads.
- Write to register 0: dropped. No capture and wb_pending is not asserted.
- Read path (combinational, per port):
  - addr==0 -> 0.
  - Else if BYPASS=1, pend_valid=1 and addr==pend_addr -> pend_data.
  - Else -> array[addr].
- Latency:
  - A write presented in cycle N is readable in cycle N+1 via bypass.
  - It reaches the array at the edge ending cycle N+1.
  - With BYPASS=0 it is readable in cycle N+2.
- Same-cycle read of the address being written returns the old value. There is no combinational write-to-read forwarding, which matches a standard single-cycle register file.
- Back-to-back writes to the same register: the newest value always wins on read. No data loss.
- wb_pending = pend_valid (registered).
- X/unknown addresses are not handled specially; the bench drives only known values.

Decomposition:
- Shared package `regfile_pkg`:
  - DATA_W and ADDR_W constants;
  - REG_ZERO = 5'd0;
  - named register indices used in tests: t0=8, s0=16, ra=31.
- One natural sub-module, `wb_stage_buf`: the pending valid/addr/data register with its capture/commit logic. It is instantiated once.
- Read muxing and the array stay in `reg_file_wb`. The two read ports are identical logic and use a generate or a function, not separate modules.

Test Plan:
- Reset: preload by writing reg 5 = 0x1234 and letting it commit, then assert reset 1 cycle -> read_addr1=5 returns 0x0000 and wb_pending=0.
- Basic write/bypass:
  - cycle 0: reg_write=1, write_addr=8, write_data=0xBEEF;
  - cycle 1: read_addr1=8 -> 0xBEEF with wb_pending=1;
  - cycle 2: 0xBEEF from the array with wb_pending=0.
- BYPASS=0 instance, same stimulus -> cycle 1 returns the old value 0x0000; cycle 2 returns 0xBEEF.
- Zero register: write addr 0 data 0xFFFF -> wb_pending stays 0; read_addr1=read_addr2=0 returns 0x0000 on both ports.
- Back-to-back same address:
  - cycle 0: write 16 = 0x1111; cycle 1: write 16 = 0x2222;
  - cycle 2: read 16 -> 0x2222 (bypass);
  - cycle 3: read 16 -> 0x2222 (array);
  - read_data2 on addr 31 is unaffected.
- Reset mid-write: cycle 0 write 31 = 0xA5A5; cycle 1 reset=1 -> cycle 2 reads 31 = 0x0000; the pending write is never committed.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file: data/address widths, the hardwired
// zero register and a few named register indices.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] T0       = 5'd8;
    localparam logic [4:0] S0       = 5'd16;
    localparam logic [4:0] RA       = 5'd31;

endpackage

// File: rtl/wb_stage_buf.sv
// One-entry write-back staging buffer: captures a register write and presents
// it for one cycle as a pending commit to the register array.
module wb_stage_buf #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] pend_data
);
    import regfile_pkg::*;

    // Writes aimed at register 0 are dropped here, so they never become pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else if (reg_write && (write_addr != ADDR_W'(REG_ZERO))) begin
            pend_valid <= 1'b1;
            pend_addr  <= write_addr;
            pend_data  <= write_data;
        end else begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Register file with a staged write-back path and combinational reads that
// forward from the staging buffer; register 0 always reads as zero.
module reg_file_wb #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              wb_pending
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    wb_stage_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_stage_buf (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    // The array only ever takes the previous cycle's captured write; a reset
    // discards whatever is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (pend_valid) begin
            regs[pend_addr] <= pend_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] arr_val,
        input logic              pv,
        input logic [ADDR_W-1:0] pa,
        input logic [DATA_W-1:0] pd
    );
        if (addr == ADDR_W'(REG_ZERO)) begin
            return '0;
        end else if ((BYPASS != 0) && pv && (addr == pa)) begin
            return pd;
        end else begin
            return arr_val;
        end
    endfunction

    assign read_data1 = read_mux(read_addr1, regs[read_addr1], pend_valid, pend_addr, pend_data);
    assign read_data2 = read_mux(read_addr2, regs[read_addr2], pend_valid, pend_addr, pend_data);
    assign wb_pending = pend_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: drives a bypassing and a non-bypassing instance with
// the same stimulus and checks both against a write-history reference model.
module tb_reg_file_wb;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [15:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [15:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        pend_b, pend_n;

    reg_file_wb #(.BYPASS(1)) dut_byp (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (rd1_b),
        .read_data2 (rd2_b),
        .wb_pending (pend_b)
    );

    reg_file_wb #(.BYPASS(0)) dut_nobyp (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (rd1_n),
        .read_data2 (rd2_n),
        .wb_pending (pend_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every accepted write with the cycle it was presented in.
    // A read in cycle C sees the newest write to that address presented at or
    // before C-1 (bypass) or C-2 (array only), ignoring anything up to a reset.
    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t hist[$];
    int  cyc        = 0;
    int  last_reset = -1;
    int  assertions = 0;
    int  failures   = 0;

    function automatic logic [15:0] model_read(input logic [4:0] addr, input int lag);
        if (addr == 5'd0) return 16'h0000;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].cyc > last_reset && hist[i].cyc <= cyc - lag && hist[i].addr == addr)
                return hist[i].data;
        end
        return 16'h0000;
    endfunction

    function automatic logic model_pending();
        if (hist.size() == 0) return 1'b0;
        return (hist[hist.size()-1].cyc == cyc - 1) && (hist[hist.size()-1].cyc > last_reset);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] wa,
                                 input logic [15:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        reset      = rst;
        reg_write  = rw;
        write_addr = wa;
        write_data = wd;
        read_addr1 = a1;
        read_addr2 = a2;
        #1;
    endtask

    task automatic checkModel();
        checkOutput("model_rd1_byp",    rd1_b, model_read(read_addr1, 1));
        checkOutput("model_rd2_byp",    rd2_b, model_read(read_addr2, 1));
        checkOutput("model_rd1_nobyp",  rd1_n, model_read(read_addr1, 2));
        checkOutput("model_rd2_nobyp",  rd2_n, model_read(read_addr2, 2));
        checkOutput("model_pend_byp",   {15'd0, pend_b}, {15'd0, model_pending()});
        checkOutput("model_pend_nobyp", {15'd0, pend_n}, {15'd0, model_pending()});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset)
            last_reset = cyc;
        else if (reg_write && write_addr != 5'd0)
            hist.push_back('{cyc: cyc, addr: write_addr, data: write_data});
        cyc++;
    endtask

    initial begin
        logic [4:0]  last_wa;
        logic [4:0]  wa, a1, a2;
        logic        rst, rw;
        logic [15:0] wd;

        reset = 1'b1; reg_write = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0;
        applyStimulus(1, 0, 0, 16'h0, 0, 0); tick();

        // Reset clears a committed value
        applyStimulus(0, 1, 5'd5, 16'h1234, 5'd5, 0); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, 5'd5, 0); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, 5'd5, 0); checkModel();
        checkOutput("preload_committed", rd1_n, 16'h1234); tick();
        applyStimulus(1, 0, 0, 16'h0, 5'd5, 0); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, 5'd5, 0); checkModel();
        checkOutput("reset_clears_reg", rd1_b, 16'h0000);
        checkOutput("reset_pending_low", {15'd0, pend_b}, 16'h0000); tick();

        // Basic write with bypass, same-cycle read sees the old value
        applyStimulus(0, 1, T0, 16'hBEEF, T0, 0); checkModel();
        checkOutput("same_cycle_old", rd1_b, 16'h0000); tick();
        applyStimulus(0, 0, 0, 16'h0, T0, 0); checkModel();
        checkOutput("bypass_value", rd1_b, 16'hBEEF);
        checkOutput("nobyp_old_value", rd1_n, 16'h0000);
        checkOutput("bypass_pending", {15'd0, pend_b}, 16'h0001); tick();
        applyStimulus(0, 0, 0, 16'h0, T0, 0); checkModel();
        checkOutput("array_value_byp", rd1_b, 16'hBEEF);
        checkOutput("array_value_nobyp", rd1_n, 16'hBEEF);
        checkOutput("pending_cleared", {15'd0, pend_b}, 16'h0000); tick();

        // Writes to register 0 are dropped
        applyStimulus(0, 1, REG_ZERO, 16'hFFFF, 0, 0); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, 0, 0); checkModel();
        checkOutput("zero_no_pending", {15'd0, pend_b}, 16'h0000);
        checkOutput("zero_rd1", rd1_b, 16'h0000);
        checkOutput("zero_rd2", rd2_b, 16'h0000); tick();

        // Back-to-back writes to the same register, port 2 watching ra
        applyStimulus(0, 1, RA, 16'h7777, 0, RA); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, 0, RA); checkModel(); tick();
        applyStimulus(0, 1, S0, 16'h1111, S0, RA); checkModel(); tick();
        applyStimulus(0, 1, S0, 16'h2222, S0, RA); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, S0, RA); checkModel();
        checkOutput("b2b_bypass", rd1_b, 16'h2222);
        checkOutput("b2b_ra_unaffected", rd2_b, 16'h7777); tick();
        applyStimulus(0, 0, 0, 16'h0, S0, RA); checkModel();
        checkOutput("b2b_array_byp", rd1_b, 16'h2222);
        checkOutput("b2b_array_nobyp", rd1_n, 16'h2222);
        checkOutput("b2b_ra_array", rd2_n, 16'h7777); tick();

        // Reset mid-write discards the pending write
        applyStimulus(0, 1, RA, 16'hA5A5, RA, 0); checkModel(); tick();
        applyStimulus(1, 0, 0, 16'h0, RA, 0); checkModel(); tick();
        applyStimulus(0, 0, 0, 16'h0, RA, RA); checkModel();
        checkOutput("midreset_rd_byp", rd1_b, 16'h0000); tick();
        applyStimulus(0, 0, 0, 16'h0, RA, RA); checkModel();
        checkOutput("midreset_not_committed", rd1_n, 16'h0000); tick();

        // Randomised traffic, reads biased toward recently written registers
        last_wa = T0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            a1  = ($urandom_range(0, 1) == 0) ? last_wa : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(rst, rw, wa, wd, a1, a2);
            checkModel();
            tick();
            if (rw) last_wa = wa;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
